// File: rtl/mem_access_unit_if.sv
// Load/store bundle between the pipeline MEM stage, the access unit and the data memory.
// The master side is the requester and memory environment; the slave side is mem_access_unit.
interface mem_access_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [8:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [6:0]  mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit for a 128x32 word-addressed data memory; sub-word stores use read-modify-write.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned requests with resp_err_o instead of force-aligning them.
module mem_access_unit (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LD    = 2'd1,
        S_ST_RD = 2'd2,
        S_ST_WR = 2'd3
    } state_e;

    state_e      state_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] sdata_q;
    logic [31:0] wbuf_q;
    logic [6:0]  mem_addr_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        accept;
    logic [1:0]  size_d;
    logic [8:0]  addr_d;
    logic        req_err_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [3:0]  byte_en;
    logic [31:0] sdata_rep;
    logic [31:0] merged;

    assign accept = bus.req_valid_i & (state_q == S_IDLE);
    assign size_d = (bus.req_size_i == 2'b11) ? 2'b10 : bus.req_size_i;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign addr_d    = bus.req_addr_i;
    assign req_err_d = ((size_d == 2'b01) & bus.req_addr_i[0]) |
                       ((size_d == 2'b10) & (|bus.req_addr_i[1:0]));
`else
    // Force-align: the request proceeds on the containing half/word.
    always_comb begin
        addr_d = bus.req_addr_i;
        if (size_d == 2'b10)
            addr_d[1:0] = 2'b00;
        else if (size_d == 2'b01)
            addr_d[0] = 1'b0;
    end
    assign req_err_d = 1'b0;
`endif

    // Load lane selection and extension from the combinational memory read.
    always_comb begin
        ld_byte = bus.mem_rdata_i[7:0];
        case (off_q)
            2'd1:    ld_byte = bus.mem_rdata_i[15:8];
            2'd2:    ld_byte = bus.mem_rdata_i[23:16];
            2'd3:    ld_byte = bus.mem_rdata_i[31:24];
            default: ld_byte = bus.mem_rdata_i[7:0];
        endcase
        ld_half = off_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = bus.mem_rdata_i;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                byte_en   = 4'b0001 << off_q;
                sdata_rep = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                byte_en   = off_q[1] ? 4'b1100 : 4'b0011;
                sdata_rep = {2{sdata_q[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                sdata_rep = sdata_q;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = byte_en[gi] ? sdata_rep[8*gi +: 8]
                                                   : bus.mem_rdata_i[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            sdata_q      <= 32'd0;
            wbuf_q       <= 32'd0;
            mem_addr_q   <= 7'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        size_q     <= size_d;
                        uns_q      <= bus.req_unsigned_i;
                        off_q      <= addr_d[1:0];
                        sdata_q    <= bus.req_wdata_i;
                        mem_addr_q <= addr_d[8:2];
                        if (req_err_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else if (!bus.req_we_i) begin
                            state_q    <= S_LD;
                            mem_read_q <= 1'b1;
                        end else if (size_d == 2'b10) begin
                            state_q     <= S_ST_WR;
                            wbuf_q      <= bus.req_wdata_i;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= S_ST_RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                S_LD: begin
                    state_q      <= S_IDLE;
                    mem_read_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_ext;
                end
                S_ST_RD: begin
                    state_q     <= S_ST_WR;
                    wbuf_q      <= merged;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                end
                S_ST_WR: begin
                    state_q      <= S_IDLE;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_read_o   = mem_read_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_wdata_o  = wbuf_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 128x32 data memory.
// Misalignment expectations follow MEM_ACCESS_MISALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    int   wr_cnt;
    logic [31:0] tb_mem [0:127];

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata_i = tb_mem[bus.mem_addr_o];

    always @(posedge clk) begin
        if (bus.mem_write_o) begin
            tb_mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current cycle and ends in its response cycle.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [8:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] exp_rdata, input logic exp_err);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        check({tag, "/ready"}, {31'd0, bus.req_ready_o}, 32'd1);
        step();
        bus.req_valid_i = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check({tag, "/early_resp"}, {31'd0, bus.resp_valid_o}, 32'd0);
            step();
        end
        check({tag, "/resp_valid"}, {31'd0, bus.resp_valid_o}, 32'd1);
        check({tag, "/rdata"}, bus.resp_rdata_o, exp_rdata);
        check({tag, "/err"}, {31'd0, bus.resp_err_o}, {31'd0, exp_err});
        $display("txn %-12s we=%0d size=%0d uns=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d",
                 tag, we, size, uns, addr, wdata, bus.resp_rdata_o, bus.resp_err_o);
    endtask

    // Back-to-back stimulus table.
    logic        bb_we   [0:2];
    logic [1:0]  bb_size [0:2];
    logic [8:0]  bb_addr [0:2];
    logic [31:0] bb_wdat [0:2];
    logic [7:0]  bb_ready_exp;
    logic [7:0]  bb_resp_exp;

    initial begin
        int w0;
        int idx;
        logic acc;

        n_cmp = 0;
        n_mis = 0;
        wr_cnt = 0;
        rst = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 9'd0;
        bus.req_wdata_i    = 32'd0;

        step();
        step();
        check("rst/ready",      {31'd0, bus.req_ready_o},  32'd1);
        check("rst/resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        check("rst/err",        {31'd0, bus.resp_err_o},   32'd0);
        check("rst/mem_read",   {31'd0, bus.mem_read_o},   32'd0);
        check("rst/mem_write",  {31'd0, bus.mem_write_o},  32'd0);
        check("rst/rdata",      bus.resp_rdata_o,          32'd0);
        check("rst/mem_addr",   {25'd0, bus.mem_addr_o},   32'd0);
        check("rst/mem_wdata",  bus.mem_wdata_o,           32'd0);
        #3 rst = 1'b0;
        step();

        // Word store then word load at 0x010.
        w0 = wr_cnt;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b10;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 9'h010; bus.req_wdata_i = 32'hDEADBEEF;
        check("wst/ready", {31'd0, bus.req_ready_o}, 32'd1);
        step();
        bus.req_valid_i = 1'b0;
        check("wst/mem_write", {31'd0, bus.mem_write_o}, 32'd1);
        check("wst/mem_read",  {31'd0, bus.mem_read_o},  32'd0);
        check("wst/mem_addr",  {25'd0, bus.mem_addr_o},  32'd4);
        check("wst/mem_wdata", bus.mem_wdata_o,          32'hDEADBEEF);
        step();
        check("wst/resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
        check("wst/rdata",      bus.resp_rdata_o,          32'd0);
        check("wst/mem_write_off", {31'd0, bus.mem_write_o}, 32'd0);
        check("wst/write_pulses", wr_cnt - w0, 32'd1);
        $display("txn %-12s we=1 size=2 addr=010 wdata=deadbeef", "wst");
        do_req("wld", 1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 2, 32'hDEADBEEF, 1'b0);

        // Byte store into preset word 4, then byte/half loads.
        do_req("preset4", 1'b1, 2'b10, 1'b0, 9'h010, 32'h11223344, 2, 32'd0, 1'b0);
        do_req("bst",     1'b1, 2'b00, 1'b0, 9'h013, 32'h000000AB, 3, 32'd0, 1'b0);
        check("bst/mem4", tb_mem[4], 32'hAB223344);
        do_req("lb_s",    1'b0, 2'b00, 1'b0, 9'h013, 32'd0, 2, 32'hFFFFFFAB, 1'b0);
        do_req("lb_u",    1'b0, 2'b00, 1'b1, 9'h013, 32'd0, 2, 32'h000000AB, 1'b0);
        do_req("lb_u1",   1'b0, 2'b00, 1'b1, 9'h011, 32'd0, 2, 32'h00000033, 1'b0);
        do_req("lb_s2",   1'b0, 2'b00, 1'b0, 9'h012, 32'd0, 2, 32'h00000022, 1'b0);
        do_req("lh_s0",   1'b0, 2'b01, 1'b0, 9'h010, 32'd0, 2, 32'h00003344, 1'b0);

        // Half store into zeroed word 8.
        do_req("preset8", 1'b1, 2'b10, 1'b0, 9'h020, 32'h00000000, 2, 32'd0, 1'b0);
        do_req("hst",     1'b1, 2'b01, 1'b0, 9'h022, 32'h00008001, 3, 32'd0, 1'b0);
        check("hst/mem8", tb_mem[8], 32'h80010000);
        do_req("lh_s",    1'b0, 2'b01, 1'b0, 9'h022, 32'd0, 2, 32'hFFFF8001, 1'b0);
        do_req("lh_u",    1'b0, 2'b01, 1'b1, 9'h022, 32'd0, 2, 32'h00008001, 1'b0);

        // Misaligned word load at 0x005.
        do_req("preset1", 1'b1, 2'b10, 1'b0, 9'h004, 32'hCAFEF00D, 2, 32'd0, 1'b0);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        do_req("mis_ld",  1'b0, 2'b10, 1'b0, 9'h005, 32'd0, 1, 32'd0, 1'b1);
        check("mis/mem_read",  {31'd0, bus.mem_read_o},  32'd0);
        check("mis/mem_write", {31'd0, bus.mem_write_o}, 32'd0);
`else
        do_req("mis_ld",  1'b0, 2'b10, 1'b0, 9'h005, 32'd0, 2, 32'hCAFEF00D, 1'b0);
        check("mis/mem_addr", {25'd0, bus.mem_addr_o}, 32'd1);
`endif
        step();

        // Back-to-back: load, byte store, load with valid held high.
        bb_we[0] = 1'b0; bb_size[0] = 2'b10; bb_addr[0] = 9'h010; bb_wdat[0] = 32'd0;
        bb_we[1] = 1'b1; bb_size[1] = 2'b00; bb_addr[1] = 9'h011; bb_wdat[1] = 32'h00000055;
        bb_we[2] = 1'b0; bb_size[2] = 2'b10; bb_addr[2] = 9'h010; bb_wdat[2] = 32'd0;
        bb_ready_exp = 8'b1010_0101;
        bb_resp_exp  = 8'b1010_0100;
        idx = 0;
        bus.req_valid_i = 1'b1; bus.req_unsigned_i = 1'b0;
        bus.req_we_i = bb_we[0]; bus.req_size_i = bb_size[0];
        bus.req_addr_i = bb_addr[0]; bus.req_wdata_i = bb_wdat[0];
        for (int c = 0; c < 8; c++) begin
            check($sformatf("bb/ready_c%0d", c), {31'd0, bus.req_ready_o}, {31'd0, bb_ready_exp[c]});
            check($sformatf("bb/resp_c%0d", c),  {31'd0, bus.resp_valid_o}, {31'd0, bb_resp_exp[c]});
            if (c == 2) check("bb/rdata_c2", bus.resp_rdata_o, 32'hAB223344);
            if (c == 7) check("bb/rdata_c7", bus.resp_rdata_o, 32'hAB225544);
            $display("txn bb cycle=%0d ready=%0d resp=%0d rdata=%08h",
                     c, bus.req_ready_o, bus.resp_valid_o, bus.resp_rdata_o);
            acc = bus.req_valid_i & bus.req_ready_o;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    bus.req_we_i = bb_we[idx]; bus.req_size_i = bb_size[idx];
                    bus.req_addr_i = bb_addr[idx]; bus.req_wdata_i = bb_wdat[idx];
                end else begin
                    bus.req_valid_i = 1'b0;
                end
            end
        end
        check("bb/mem4", tb_mem[4], 32'hAB225544);

        // Reset during ST_RD of a byte store.
        w0 = wr_cnt;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b00;
        bus.req_addr_i = 9'h010; bus.req_wdata_i = 32'h00000077;
        step();
        bus.req_valid_i = 1'b0;
        check("rmid/mem_read_before", {31'd0, bus.mem_read_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rmid/mem_read",  {31'd0, bus.mem_read_o},  32'd0);
        check("rmid/mem_write", {31'd0, bus.mem_write_o}, 32'd0);
        step();
        check("rmid/resp_in_rst", {31'd0, bus.resp_valid_o}, 32'd0);
        #3 rst = 1'b0;
        check("rmid/mem4", tb_mem[4], 32'hAB225544);
        check("rmid/writes", wr_cnt - w0, 32'd0);
        $display("txn %-12s reset abort of byte store at 010", "rmid");
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10;
        bus.req_addr_i = 9'h010;
        check("rmid/ready_after", {31'd0, bus.req_ready_o}, 32'd1);
        step();
        bus.req_valid_i = 1'b0;
        check("rmid/resp_after", {31'd0, bus.resp_valid_o}, 32'd0);
        check("rmid/accepted", {31'd0, bus.mem_read_o}, 32'd1);
        step();
        check("rmid/ld_valid", {31'd0, bus.resp_valid_o}, 32'd1);
        check("rmid/ld_rdata", bus.resp_rdata_o, 32'hAB225544);
        $display("txn %-12s rdata=%08h", "rmid_ld", bus.resp_rdata_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
